// File: rtl/loop_ctrl_pkg.sv
// loop_ctrl_pkg: shared state encoding for the loop control FSM
package loop_ctrl_pkg;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
endpackage

// File: rtl/dec_unit.sv
// dec_unit: combinational unsigned decrement, wraps modulo 2^DATAWIDTH
module dec_unit #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] d
);
    assign d = a - DATAWIDTH'(1);
endmodule

// File: rtl/loop_down_counter.sv
// loop_down_counter: loads an iteration count and issues one index per handshake, counting down to 0
module loop_down_counter
    import loop_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] count,
    input  logic                 iter_ack,
    input  logic                 abort,
    output logic                 busy,
    output logic                 iter_valid,
    output logic [DATAWIDTH-1:0] iter_idx,
    output logic [DATAWIDTH-1:0] remaining,
    output logic                 done
);
    logic [1:0]           state;
    logic [DATAWIDTH-1:0] rem_dec;
    logic [DATAWIDTH-1:0] idx_dec;

    dec_unit #(.DATAWIDTH(DATAWIDTH)) u_dec_rem (.a(remaining), .d(rem_dec));
    // In IDLE this produces the load index count-1, in RUN the next index
    dec_unit #(.DATAWIDTH(DATAWIDTH)) u_dec_idx (.a(state == ST_RUN ? iter_idx : count), .d(idx_dec));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            iter_valid <= 1'b0;
            iter_idx   <= '0;
            remaining  <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && count != '0) begin
                        remaining  <= count;
                        iter_idx   <= idx_dec;
                        iter_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_RUN;
                    end else if (start) begin
                        busy  <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        iter_valid <= 1'b0;
                        iter_idx   <= '0;
                        remaining  <= '0;
                    end else if (iter_ack && remaining != DATAWIDTH'(1)) begin
                        remaining <= rem_dec;
                        iter_idx  <= idx_dec;
                    end else if (iter_ack) begin
                        remaining  <= '0;
                        iter_idx   <= '0;
                        iter_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
